// File: rtl/serial_chunk_adder_if.sv
// Operand/result bundle for serial_chunk_adder: start/busy/done handshake plus
// operands in and registered result out.
interface serial_chunk_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract: processes CHUNK bits per clock, LSB chunk first,
// through a registered carry; result is published only when done pulses.
module serial_chunk_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_chunk_adder_if.slave bus
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("serial_chunk_adder: WIDTH must be a nonzero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [31:0]      idx_c;
  logic [CHUNK-1:0] ca_c;
  logic [CHUNK-1:0] cb_c;
  logic [CHUNK:0]   ext_c;
  logic             msb_cin_c;
  logic [WIDTH-1:0] acc_next_c;

  // Chunk adder; the carry into the chunk MSB is recovered from the sum bit.
  always_comb begin
    idx_c      = 32'(cnt) * 32'(CHUNK);
    ca_c       = CHUNK'(op_a >> idx_c);
    cb_c       = CHUNK'(op_b >> idx_c);
    ext_c      = {1'b0, ca_c} + {1'b0, cb_c} + {{CHUNK{1'b0}}, carry};
    msb_cin_c  = ext_c[CHUNK-1] ^ ca_c[CHUNK-1] ^ cb_c[CHUNK-1];
    acc_next_c = acc | (WIDTH'(ext_c[CHUNK-1:0]) << idx_c);
  end

  // Control and datapath; acc is cleared at capture so chunks can be OR-ed in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_a         <= '0;
      op_b         <= '0;
      acc          <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sum      <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_a     <= bus.a;
            op_b     <= bus.b ^ {WIDTH{bus.sub}};
            carry    <= bus.sub | bus.cin;
            cnt      <= '0;
            acc      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next_c;
          carry <= ext_c[CHUNK];
          if (cnt == CW'(N - 1)) begin
            bus.sum      <= acc_next_c;
            bus.cout     <= ext_c[CHUNK];
            bus.overflow <= msb_cin_c ^ ext_c[CHUNK];
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed bench for serial_chunk_adder: 8/1 handshake and corner cases,
// plus 8/4 and 4/4 sweeps against an arithmetic reference.
module tb_serial_chunk_adder;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [7:0] last_sum;
  logic [7:0] blist [16] = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h3C, 8'h55, 8'h7E,
                             8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hFE, 8'hFF};

  serial_chunk_adder_if #(.WIDTH(8)) if81 ();
  serial_chunk_adder_if #(.WIDTH(8)) if84 ();
  serial_chunk_adder_if #(.WIDTH(4)) if44 ();

  serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut81 (.clk(clk), .rst_n(rst_n), .bus(if81));
  serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut84 (.clk(clk), .rst_n(rst_n), .bus(if84));
  serial_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut44 (.clk(clk), .rst_n(rst_n), .bus(if44));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge (E0) and check acceptance.
  task automatic start81(input logic s, input logic [7:0] av, input logic [7:0] bv,
                         input logic c);
    if81.sub = s; if81.a = av; if81.b = bv; if81.cin = c; if81.start = 1'b1;
    tick();
    if81.start = 1'b0;
    chk("81 busy after accept", 32'(if81.busy), 1);
    chk("81 done after accept", 32'(if81.done), 0);
  endtask

  // Called after edge E(from); runs to E8 and checks the published result.
  task automatic finish81(input int from, input logic [7:0] es, input logic ec,
                          input logic eo, input string tag);
    for (int k = from + 1; k < 8; k++) begin
      tick();
      chk({tag, " busy mid"}, 32'(if81.busy), 1);
      chk({tag, " done mid"}, 32'(if81.done), 0);
      chk({tag, " sum held"}, 32'(if81.sum), 32'(last_sum));
    end
    tick();
    chk({tag, " busy end"}, 32'(if81.busy), 0);
    chk({tag, " done end"}, 32'(if81.done), 1);
    chk({tag, " sum"}, 32'(if81.sum), 32'(es));
    chk({tag, " cout"}, 32'(if81.cout), 32'(ec));
    chk({tag, " overflow"}, 32'(if81.overflow), 32'(eo));
    last_sum = es;
  endtask

  task automatic run81(input logic s, input logic [7:0] av, input logic [7:0] bv,
                       input logic c, input logic [7:0] es, input logic ec,
                       input logic eo, input string tag);
    start81(s, av, bv, c);
    finish81(0, es, ec, eo, tag);
    tick();
    chk({tag, " done drop"}, 32'(if81.done), 0);
  endtask

  task automatic op44(input logic s, input logic [3:0] av, input logic [3:0] bv,
                      input logic c);
    logic [3:0] bb;
    logic [4:0] r;
    logic       ov;
    bb = s ? ~bv : bv;
    r  = {1'b0, av} + {1'b0, bb} + {4'b0, (s | c)};
    ov = (av[3] == bb[3]) && (r[3] != av[3]);
    if44.sub = s; if44.a = av; if44.b = bv; if44.cin = c; if44.start = 1'b1;
    tick();
    if44.start = 1'b0;
    chk("44 busy run", 32'(if44.busy), 1);
    chk("44 done run", 32'(if44.done), 0);
    tick();
    chk("44 busy end", 32'(if44.busy), 0);
    chk("44 done end", 32'(if44.done), 1);
    chk("44 sum", 32'(if44.sum), 32'(r[3:0]));
    chk("44 cout", 32'(if44.cout), 32'(r[4]));
    chk("44 overflow", 32'(if44.overflow), 32'(ov));
  endtask

  task automatic op84(input logic s, input logic [7:0] av, input logic [7:0] bv,
                      input logic c);
    logic [7:0] bb;
    logic [8:0] r;
    logic       ov;
    bb = s ? ~bv : bv;
    r  = {1'b0, av} + {1'b0, bb} + {8'b0, (s | c)};
    ov = (av[7] == bb[7]) && (r[7] != av[7]);
    if84.sub = s; if84.a = av; if84.b = bv; if84.cin = c; if84.start = 1'b1;
    tick();
    if84.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) tick();
      chk("84 busy run", 32'(if84.busy), 1);
      chk("84 done run", 32'(if84.done), 0);
    end
    tick();
    chk("84 busy end", 32'(if84.busy), 0);
    chk("84 done end", 32'(if84.done), 1);
    chk("84 sum", 32'(if84.sum), 32'(r[7:0]));
    chk("84 cout", 32'(if84.cout), 32'(r[8]));
    chk("84 overflow", 32'(if84.overflow), 32'(ov));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    last_sum = 8'h00;
    rst_n    = 1'b1;
    if81.start = 1'b0; if81.sub = 1'b0; if81.a = '0; if81.b = '0; if81.cin = 1'b0;
    if84.start = 1'b0; if84.sub = 1'b0; if84.a = '0; if84.b = '0; if84.cin = 1'b0;
    if44.start = 1'b0; if44.sub = 1'b0; if44.a = '0; if44.b = '0; if44.cin = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    chk("reset busy", 32'(if81.busy), 0);
    chk("reset done", 32'(if81.done), 0);
    chk("reset sum", 32'(if81.sum), 0);
    chk("reset cout", 32'(if81.cout), 0);
    chk("reset overflow", 32'(if81.overflow), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle busy", 32'(if81.busy), 0);

    // Basic add/sub vectors
    run81(1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add 5A+3C");
    run81(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add FF+01");
    run81(1'b0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, "add FF+01+1");
    run81(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "add 7F+01");
    run81(1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0, "sub 10-20");
    run81(1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub 10-20 cin ignored");
    run81(1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, "sub 80-01");

    // Start while busy is ignored; start in the done cycle is accepted
    start81(1'b0, 8'h12, 8'h34, 1'b0);
    tick();
    tick();
    if81.a = 8'hFF; if81.b = 8'hFF; if81.cin = 1'b1; if81.start = 1'b1;
    tick();
    if81.start = 1'b0;
    chk("ignored start busy", 32'(if81.busy), 1);
    finish81(3, 8'h46, 1'b0, 1'b0, "first of pair");
    start81(1'b1, 8'h20, 8'h05, 1'b0);
    finish81(0, 8'h1B, 1'b1, 1'b0, "back to back");
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("single done pulse", 32'(if81.done), 0);
    end

    // Asynchronous reset mid-operation
    start81(1'b0, 8'h5A, 8'h3C, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(if81.busy), 0);
    chk("abort done", 32'(if81.done), 0);
    chk("abort sum", 32'(if81.sum), 0);
    chk("abort cout", 32'(if81.cout), 0);
    chk("abort overflow", 32'(if81.overflow), 0);
    tick();
    rst_n = 1'b1;
    last_sum = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("no done after abort", 32'(if81.done), 0);
    end
    run81(1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "after abort");

    // Single-cycle variant, all operand combinations
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int m = 0; m < 4; m++)
          op44(m[1], 4'(ai), 4'(bi), m[0]);

    // Two-chunk variant, all a against a spread of b values
    for (int ai = 0; ai < 256; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int m = 0; m < 4; m++)
          op84(m[1], 8'(ai), blist[bi], m[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
